// File: rtl/z_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, NOP
// encoding, fetch FSM state encoding and an alignment helper.
package z_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] Z_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_t;

  // A fetch address is legal only when it points at a whole 32-bit word.
  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/z_fetch_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and the
// instruction memory (slave). One request outstanding at a time.
interface z_fetch_if;
  import z_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;
  logic              imem_err;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  imem_err
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output imem_err
  );

endinterface

// File: rtl/z_fetch_timer.sv
// Fetch wait counter. Counts request cycles that pass without an ack and
// flags expiry on the last allowed cycle, so the request is live for exactly
// TIMEOUT_CYCLES cycles before the fetch stage faults. Only built when
// Z_FETCH_TIMEOUT_EN is defined.
module z_fetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;

  // Count unanswered request cycles; any idle or acked cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (active && !ack) begin
      count_q <= count_q + 8'd1;
    end else begin
      count_q <= '0;
    end
  end

  // An ack in the expiring cycle is given priority by the fetch FSM.
  assign expire = active && (count_q == LAST_COUNT);

endmodule

// File: rtl/z_fetch.sv
// Instruction-fetch stage feeding z_controller. Owns the PC, fetches one
// word per instruction over the imem req/ack bus (one in flight), holds the
// instruction until the controller commits it, then loads next_pc.
// Optional build macro: Z_FETCH_TIMEOUT_EN adds a request wait timeout that
// drives the stage into its sticky fault state.
module z_fetch
  import z_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  z_fetch_if.master         imem,
  input  logic [WORD_W-1:0] next_pc,
  input  logic              stall,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] pc,
  output logic              inst_valid,
  output logic              fetch_fault
);

  // Reject configurations the hardware cannot honour.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("z_fetch: RESET_PC must be word-aligned");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("z_fetch: TIMEOUT_CYCLES must be in 1..255");
  end

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] inst_q, inst_d;
  logic              req_q;
  logic              valid_q;
  logic              fault_q;

  logic              req_active;
  logic              commit;
  logic              timeout_expire;

  // The request is live only once the registered req is up; the cycle right
  // after reset release sits in S_REQ with req still low and ignores acks.
  assign req_active = (state_q == S_REQ) && req_q;
  assign commit     = (state_q == S_HOLD) && valid_q && !stall;

`ifdef Z_FETCH_TIMEOUT_EN
  z_fetch_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .active (req_active),
    .ack    (imem.imem_ack),
    .expire (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // Next-state and next-datapath decisions for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_REQ: begin
        if (req_active && imem.imem_ack) begin
          if (imem.imem_err) begin
            state_d = S_FAULT;
          end else begin
            inst_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end else if (timeout_expire) begin
          state_d = S_FAULT;
        end
      end
      S_HOLD: begin
        if (commit) begin
          pc_d    = next_pc;
          state_d = is_word_aligned(next_pc) ? S_REQ : S_FAULT;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // State, PC, instruction and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= Z_NOP;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      req_q   <= (state_d == S_REQ);
      valid_q <= (state_d == S_HOLD);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  assign inst        = valid_q ? inst_q : Z_NOP;
  assign pc          = pc_q;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_z_fetch.sv
// Testbench for z_fetch: directed scenarios followed by randomized bus and
// controller traffic, all checked against a transaction-level reference model.
module tb_z_fetch;

  localparam logic [31:0] RESET_PC       = 32'h0040_0000;
  localparam int          TIMEOUT_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        fetch_fault;

  z_fetch_if bus ();

  z_fetch #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .next_pc     (next_pc),
    .stall       (stall),
    .inst        (inst),
    .pc          (pc),
    .inst_valid  (inst_valid),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the fetch stage should be showing the world.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_valid;
  logic        m_req;
  logic        m_fault;
  int          m_wait;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_inst  = 32'h0;
    m_valid = 1'b0;
    m_req   = 1'b0;
    m_fault = 1'b0;
    m_wait  = 0;
  endtask

  task automatic compare_all();
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("inst", inst, m_valid ? m_inst : 32'h0);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
  endtask

  // One clock: apply the fetch rules to the inputs seen at the edge, then compare.
  task automatic tick();
    logic        a, e, s, r;
    logic [31:0] d, n;
    a = bus.imem_ack; e = bus.imem_err; d = bus.imem_rdata;
    s = stall; n = next_pc; r = rst;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (m_fault) begin
      // terminal until reset
    end else if (m_req) begin
      if (a && e) begin
        m_fault = 1'b1; m_req = 1'b0;
      end else if (a) begin
        m_inst = d; m_valid = 1'b1; m_req = 1'b0;
      end else begin
        m_wait++;
`ifdef Z_FETCH_TIMEOUT_EN
        if (m_wait >= TIMEOUT_CYCLES) begin
          m_fault = 1'b1; m_req = 1'b0;
        end
`endif
      end
    end else if (m_valid) begin
      if (!s) begin
        m_pc = n; m_valid = 1'b0;
        if (n[1:0] != 2'b00) m_fault = 1'b1;
        else begin m_req = 1'b1; m_wait = 0; end
      end
    end else begin
      m_req = 1'b1; m_wait = 0;
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("async_req_drop", {31'b0, bus.imem_req}, 32'h0);
    chk("async_pc", pc, RESET_PC);
    chk("async_valid", {31'b0, inst_valid}, 32'h0);
    chk("async_fault", {31'b0, fetch_fault}, 32'h0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic idle_inputs();
    bus.imem_ack   = 1'b0;
    bus.imem_err   = 1'b0;
    bus.imem_rdata = 32'h0;
    stall          = 1'b0;
  endtask

  logic [31:0] tmp;

  initial begin
    rst = 1'b1;
    next_pc = 32'h0;
    idle_inputs();
    model_reset();

    // Reset state
    tick();
    tick();
    chk("t1_pc", pc, 32'h0040_0000);
    chk("t1_inst", inst, 32'h0);
    chk("t1_valid", {31'b0, inst_valid}, 32'h0);
    chk("t1_req", {31'b0, bus.imem_req}, 32'h0);
    rst = 1'b0;
    tick();
    chk("t1_req_up", {31'b0, bus.imem_req}, 32'h1);
    chk("t1_addr", bus.imem_addr, 32'h0040_0000);

    // First-cycle ack and commit
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2008_0005;
    tick();
    idle_inputs();
    chk("t2_inst", inst, 32'h2008_0005);
    chk("t2_valid", {31'b0, inst_valid}, 32'h1);
    next_pc = 32'h0040_0004;
    tick();
    chk("t2_req", {31'b0, bus.imem_req}, 32'h1);
    chk("t2_addr", bus.imem_addr, 32'h0040_0004);

    // Stall holds the instruction
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    tick();
    idle_inputs();
    stall = 1'b1;
    next_pc = 32'h0040_0008;
    repeat (3) tick();
    chk("t3_inst", inst, 32'h1234_5678);
    chk("t3_pc", pc, 32'h0040_0004);
    chk("t3_req", {31'b0, bus.imem_req}, 32'h0);
    stall = 1'b0;
    tick();
    chk("t3_commit_addr", bus.imem_addr, 32'h0040_0008);

    // Misaligned next_pc at commit
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_0001;
    tick();
    idle_inputs();
    next_pc = 32'h0040_0006;
    tick();
    next_pc = 32'h0040_0010;
    repeat (50) tick();
    chk("t4_fault", {31'b0, fetch_fault}, 32'h1);
    chk("t4_pc", pc, 32'h0040_0006);
    chk("t4_inst", inst, 32'h0);
    do_reset();

    // Bus error on ack
    bus.imem_ack = 1'b1; bus.imem_err = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    chk("t5_fault", {31'b0, fetch_fault}, 32'h1);
    chk("t5_inst", inst, 32'h0);
    repeat (5) tick();
    do_reset();

    // Waiting with no ack
`ifdef Z_FETCH_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 1) tick();
    chk("t6_req_before", {31'b0, bus.imem_req}, 32'h1);
    tick();
    chk("t6_timeout_fault", {31'b0, fetch_fault}, 32'h1);
    chk("t6_timeout_req", {31'b0, bus.imem_req}, 32'h0);
`else
    repeat (100) tick();
    chk("t6_req_held", {31'b0, bus.imem_req}, 32'h1);
    chk("t6_no_fault", {31'b0, fetch_fault}, 32'h0);
`endif
    do_reset();
    do_reset();
    chk("t6_refetch_addr", bus.imem_addr, RESET_PC);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 3) == 0);
      bus.imem_ack   = ($urandom_range(0, 2) == 0);
      bus.imem_err   = ($urandom_range(0, 15) == 0);
      bus.imem_rdata = $urandom;
      tmp            = $urandom;
      if ($urandom_range(0, 39) == 0) next_pc = tmp;
      else next_pc = {tmp[31:2], 2'b00};
      if ((m_fault && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
